// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and helpers for the fully-connected MAC engine
// Contents:
//   state_t       FSM states of the engine
//   clog2         ceiling log2, usable in constant expressions
//   acc_width     accumulator width that cannot overflow for a given element width and dot-product length
//   post_process  saturate to a signed out_w-bit range, then optional ReLU clamp
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } state_t;

  // Working width of post_process; every accumulator must fit inside it.
  localparam int POST_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Products are 2*bw wide; summing n of them plus a bias needs clog2(n)+1 more bits.
  function automatic int acc_width(input int bw, input int n);
    return 2 * bw + clog2(n) + 1;
  endfunction

  function automatic logic signed [POST_W-1:0] post_process(
    input logic signed [POST_W-1:0] value,
    input int                       out_w,
    input logic                     relu
  );
    logic signed [POST_W-1:0] hi;
    logic signed [POST_W-1:0] lo;
    logic signed [POST_W-1:0] r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi)      r = hi;
    else if (value < lo) r = lo;
    else                 r = value;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one signed multiply-accumulate lane with bias add and post-processing
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears the accumulator)
//   mac_en     add x*w into the accumulator this cycle
//   clear      zero the accumulator this cycle (wins over mac_en)
//   x, w       signed data and weight operands
//   b          signed bias added to the accumulator on the output path
//   y          post_process(acc + b), combinational, 2*BITWIDTH bits signed
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int INPUT_SIZE = 7,
  parameter int RELU       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mac_en,
  input  logic                          clear,
  input  logic signed [BITWIDTH-1:0]    x,
  input  logic signed [BITWIDTH-1:0]    w,
  input  logic signed [BITWIDTH-1:0]    b,
  output logic signed [2*BITWIDTH-1:0]  y
);

  localparam int ACC_W = acc_width(BITWIDTH, INPUT_SIZE);
  localparam int OUT_W = 2 * BITWIDTH;

  logic signed [OUT_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [POST_W-1:0] post_wide;

  // Operands are sign-extended before multiplying so the full signed product is kept.
  assign prod = OUT_W'(x) * OUT_W'(w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign sum       = acc + ACC_W'(b);
  assign post_wide = post_process(POST_W'(sum), OUT_W, RELU != 0);
  assign y         = post_wide[OUT_W-1:0];

endmodule

// File: rtl/fc_mac_engine.sv
// rtl/fc_mac_engine.sv - fully-connected layer engine: LANES neurons per group, one input element per cycle
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake; in_ready is high only in IDLE
//   data                 INPUT_SIZE signed elements, element j at [(j+1)*BITWIDTH-1 -: BITWIDTH]
//   weight               OUTPUT_SIZE*INPUT_SIZE signed elements, element (o,j) at index o*INPUT_SIZE+j
//   bias                 OUTPUT_SIZE signed elements, element o at index o
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   result               OUTPUT_SIZE signed 2*BITWIDTH elements, element o at index o
//   busy                 high whenever the FSM is not in IDLE
module fc_mac_engine
  import fc_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_SIZE  = 7,
  parameter int OUTPUT_SIZE = 6,
  parameter int LANES       = 2,
  parameter int RELU        = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [BITWIDTH*INPUT_SIZE-1:0]             data,
  input  logic [BITWIDTH*INPUT_SIZE*OUTPUT_SIZE-1:0] weight,
  input  logic [BITWIDTH*OUTPUT_SIZE-1:0]            bias,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [2*BITWIDTH*OUTPUT_SIZE-1:0]          result,
  output logic                                      busy
);

  // OUTPUT_SIZE must be a multiple of LANES.
  localparam int OUT_W  = 2 * BITWIDTH;
  localparam int GROUPS = OUTPUT_SIZE / LANES;
  localparam int JW     = (clog2(INPUT_SIZE) > 0) ? clog2(INPUT_SIZE) : 1;
  localparam int GW     = (clog2(GROUPS) > 0) ? clog2(GROUPS) : 1;
  localparam logic [JW-1:0] LAST_J = JW'(INPUT_SIZE - 1);
  localparam logic [GW-1:0] LAST_G = GW'(GROUPS - 1);

  state_t          state;
  logic [JW-1:0]   j;
  logic [GW-1:0]   g;
  logic            accept;
  logic            mac_en;
  logic            clear;

  // Operand snapshot, arranged by [group][lane] so the lanes index with g and j directly.
  logic signed [BITWIDTH-1:0] data_arr [INPUT_SIZE];
  logic signed [BITWIDTH-1:0] w_arr    [GROUPS][LANES][INPUT_SIZE];
  logic signed [BITWIDTH-1:0] b_arr    [GROUPS][LANES];
  logic signed [OUT_W-1:0]    res_arr  [GROUPS][LANES];
  logic signed [OUT_W-1:0]    lane_y   [LANES];

  assign accept = (state == IDLE) && in_valid;
  assign mac_en = (state == MAC);
  assign clear  = (state == BIAS);

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int jj = 0; jj < INPUT_SIZE; jj++) begin
        data_arr[jj] <= data[jj*BITWIDTH +: BITWIDTH];
      end
      for (int o = 0; o < OUTPUT_SIZE; o++) begin
        b_arr[o/LANES][o%LANES] <= bias[o*BITWIDTH +: BITWIDTH];
        for (int jj = 0; jj < INPUT_SIZE; jj++) begin
          w_arr[o/LANES][o%LANES][jj] <= weight[(o*INPUT_SIZE+jj)*BITWIDTH +: BITWIDTH];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane #(
      .BITWIDTH   (BITWIDTH),
      .INPUT_SIZE (INPUT_SIZE),
      .RELU       (RELU)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .mac_en (mac_en),
      .clear  (clear),
      .x      (data_arr[j]),
      .w      (w_arr[g][l][j]),
      .b      (b_arr[g][l]),
      .y      (lane_y[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      g         <= '0;
      j         <= '0;
      for (int gi = 0; gi < GROUPS; gi++) begin
        for (int l = 0; l < LANES; l++) begin
          res_arr[gi][l] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            g        <= '0;
            j        <= '0;
          end
        end
        MAC: begin
          if (j == LAST_J) begin
            j     <= '0;
            state <= BIAS;
          end else begin
            j <= j + 1'b1;
          end
        end
        BIAS: begin
          for (int l = 0; l < LANES; l++) begin
            res_arr[g][l] <= lane_y[l];
          end
          j <= '0;
          if (g == LAST_G) begin
            state <= DONE;
          end else begin
            g     <= g + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          // The last group lands on the BIAS->DONE edge; the result is presented
          // one cycle later, giving a fixed groups*(INPUT_SIZE+1)+1 latency.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            g         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    result = '0;
    for (int o = 0; o < OUTPUT_SIZE; o++) begin
      result[o*OUT_W +: OUT_W] = res_arr[o/LANES][o%LANES];
    end
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
// tb/tb_fc_mac_engine.sv - directed self-checking bench for fc_mac_engine (RELU=0 and RELU=1 instances)
module tb_fc_mac_engine;

  localparam int BW  = 8;
  localparam int IN  = 4;
  localparam int OUT = 4;
  localparam int LN  = 2;
  localparam int RS  = 2 * BW;
  localparam int DW  = BW * IN;
  localparam int WW  = BW * IN * OUT;
  localparam int BSW = BW * OUT;
  localparam int RW  = RS * OUT;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0]  data     = '0;
  logic [WW-1:0]  weight   = '0;
  logic [BSW-1:0] bias     = '0;

  logic          in_ready, out_valid, busy;
  logic [RW-1:0] result;
  logic          in_ready_r, out_valid_r, busy_r;
  logic [RW-1:0] result_r;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  fc_mac_engine #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .LANES(LN), .RELU(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .weight(weight), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  fc_mac_engine #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .LANES(LN), .RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .data(data), .weight(weight), .bias(bias),
    .out_valid(out_valid_r), .out_ready(out_ready), .result(result_r), .busy(busy_r)
  );

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_data(input int d0, input int d1, input int d2, input int d3);
    logic [DW-1:0] v;
    int d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    v = '0;
    for (int k = 0; k < IN; k++) v[k*BW +: BW] = BW'(d[k]);
    return v;
  endfunction

  // Every element of weight row o is r_o.
  function automatic logic [WW-1:0] pack_weight(input int r0, input int r1, input int r2, input int r3);
    logic [WW-1:0] v;
    int r [4];
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    v = '0;
    for (int o = 0; o < OUT; o++)
      for (int k = 0; k < IN; k++) v[(o*IN+k)*BW +: BW] = BW'(r[o]);
    return v;
  endfunction

  function automatic logic [BSW-1:0] pack_bias(input int b);
    logic [BSW-1:0] v;
    v = '0;
    for (int o = 0; o < OUT; o++) v[o*BW +: BW] = BW'(b);
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_res(input int e0, input int e1, input int e2, input int e3);
    logic [RW-1:0] v;
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    v = '0;
    for (int o = 0; o < OUT; o++) v[o*RS +: RS] = RS'(e[o]);
    return v;
  endfunction

  // Offers one operand set, scrambles the input ports after the accept edge,
  // and returns the number of edges from accept until out_valid is seen.
  task automatic run_txn(input string tag, input logic [DW-1:0] d, input logic [WW-1:0] w,
                         input logic [BSW-1:0] b, output int latency);
    @(posedge clk); #1;
    data = d; weight = w; bias = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data     = $urandom;
    weight   = {$urandom, $urandom, $urandom, $urandom};
    bias     = $urandom;
    chk({tag, " in_ready after accept"}, RW'(in_ready), RW'(1'b0));
    chk({tag, " busy after accept"}, RW'(busy), RW'(1'b1));
    latency = 0;
    while (!out_valid && latency < 100) begin
      @(posedge clk);
      latency++;
      #1;
    end
  endtask

  task automatic finish_txn(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after handshake"}, RW'(in_ready), RW'(1'b1));
    chk({tag, " out_valid after handshake"}, RW'(out_valid), RW'(1'b0));
    chk({tag, " busy after handshake"}, RW'(busy), RW'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset in_ready", RW'(in_ready), RW'(1'b1));
    chk("reset out_valid", RW'(out_valid), RW'(1'b0));
    chk("reset busy", RW'(busy), RW'(1'b0));
    chk("reset result", result, '0);
    chk("reset relu in_ready", RW'(in_ready_r), RW'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All ones, zero bias: every output 4, latency 2*(4+1)+1 = 11.
    run_txn("ones", pack_data(1, 1, 1, 1), pack_weight(1, 1, 1, 1), pack_bias(0), lat);
    chk("ones latency", RW'(lat), RW'(11));
    chk("ones result", result, pack_res(4, 4, 4, 4));
    chk("ones relu result", result_r, pack_res(4, 4, 4, 4));
    finish_txn("ones");

    // Row o weights (o+1), data 1..4 sums to 10, bias -5: 10*(o+1)-5.
    run_txn("ramp", pack_data(1, 2, 3, 4), pack_weight(1, 2, 3, 4), pack_bias(-5), lat);
    chk("ramp latency", RW'(lat), RW'(11));
    chk("ramp result", result, pack_res(5, 15, 25, 35));
    chk("ramp relu result", result_r, pack_res(5, 15, 25, 35));
    finish_txn("ramp");

    // 4 * (-128*-128) = 65536 saturates to 32767.
    run_txn("satpos", pack_data(-128, -128, -128, -128), pack_weight(-128, -128, -128, -128), pack_bias(0), lat);
    chk("satpos result", result, pack_res(32767, 32767, 32767, 32767));
    chk("satpos relu result", result_r, pack_res(32767, 32767, 32767, 32767));
    finish_txn("satpos");

    // 4 * (-128*127) = -65024 saturates to -32768; ReLU clamps to 0.
    run_txn("satneg", pack_data(-128, -128, -128, -128), pack_weight(127, 127, 127, 127), pack_bias(0), lat);
    chk("satneg result", result, pack_res(-32768, -32768, -32768, -32768));
    chk("satneg relu out_valid", RW'(out_valid_r), RW'(1'b1));
    chk("satneg relu result", result_r, pack_res(0, 0, 0, 0));
    finish_txn("satneg");

    // Back-pressure in DONE with in_valid toggling.
    run_txn("hold", pack_data(1, 2, 3, 4), pack_weight(1, 2, 3, 4), pack_bias(-5), lat);
    chk("hold latency", RW'(lat), RW'(11));
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      @(posedge clk); #1;
      chk("hold in_ready", RW'(in_ready), RW'(1'b0));
      chk("hold out_valid", RW'(out_valid), RW'(1'b1));
      chk("hold result", result, pack_res(5, 15, 25, 35));
    end
    in_valid = 1'b0;
    finish_txn("hold");
    chk("hold result kept in IDLE", result, pack_res(5, 15, 25, 35));
    @(posedge clk); #1;
    chk("hold no second accept", RW'(busy), RW'(1'b0));

    // Reset three edges into a transaction.
    @(posedge clk); #1;
    data = pack_data(1, 1, 1, 1); weight = pack_weight(1, 1, 1, 1); bias = pack_bias(0); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun result untouched", result, pack_res(5, 15, 25, 35));
    chk("midrun busy", RW'(busy), RW'(1'b1));
    rst = 1'b1;
    #1;
    chk("midrun reset in_ready", RW'(in_ready), RW'(1'b1));
    chk("midrun reset out_valid", RW'(out_valid), RW'(1'b0));
    chk("midrun reset busy", RW'(busy), RW'(1'b0));
    chk("midrun reset result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    run_txn("after reset", pack_data(1, 1, 1, 1), pack_weight(1, 1, 1, 1), pack_bias(0), lat);
    chk("after reset latency", RW'(lat), RW'(11));
    chk("after reset result", result, pack_res(4, 4, 4, 4));
    chk("after reset relu busy", RW'(busy_r), RW'(1'b1));
    finish_txn("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
